// File: rtl/crono_pkg.sv
// Shared definitions for the countdown timer: state codes, PS/2 key codes,
// BCD field limits and the DONE auto-return timeout.
package crono_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } estado_t;

  localparam logic [7:0] KEY_LOAD  = 8'h75;
  localparam logic [7:0] KEY_START = 8'h29;
  localparam logic [7:0] KEY_CLEAR = 8'h66;
  localparam logic [7:0] KEY_ACK   = 8'h5A;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_H  = 8'h23;
  localparam logic [7:0] BCD_ZERO   = 8'h00;

  localparam logic [4:0] TIMEOUT_TICKS = 5'd30;

  // Both digits decimal and the packed value within the field limit; once the
  // digits are legal, packed BCD orders the same way as the number it encodes.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/decremento_bcd.sv
// Two-digit packed-BCD decrement by one. A zero input yields the wrap value and
// raises the borrow towards the next more significant field.
module decremento_bcd (
  input  logic [7:0] valor,
  input  logic [7:0] envolver,
  output logic [7:0] resultado,
  output logic       prestamo
);

  // Decrement the units digit, borrowing from the tens digit or from the next field.
  always_comb begin
    resultado = valor;
    prestamo  = 1'b0;
    if (valor == 8'h00) begin
      resultado = envolver;
      prestamo  = 1'b1;
    end else if (valor[3:0] == 4'h0) begin
      resultado = {valor[7:4] - 4'd1, 4'd9};
      prestamo  = 1'b0;
    end else begin
      resultado = {valor[7:4], valor[3:0] - 4'd1};
      prestamo  = 1'b0;
    end
  end

endmodule

// File: rtl/cronometro_control.sv
// Keyboard-driven HH:MM:SS countdown timer with alarm.
// Macro CRONO_ALARM_TIMEOUT_EN: DONE returns to IDLE by itself after 30 ticks.
module cronometro_control
  import crono_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tecla,
  input  logic       tecla_valida,
  input  logic       tick_1hz,
  input  logic [7:0] Segundos,
  input  logic [7:0] Minutos,
  input  logic [7:0] Horas,
  output logic [7:0] Segundos_C,
  output logic [7:0] Minutos_C,
  output logic [7:0] Horas_C,
  output logic       alarma,
  output logic       error_carga,
  output logic [2:0] estado
);

  estado_t    state_r, state_s;
  logic [7:0] seg_r, min_r, hr_r;
  logic [7:0] seg_s, min_s, hr_s;
  logic       alarma_r, err_r, err_s;

  logic [7:0] seg_dec_s, min_dec_s, hr_dec_s;
  logic       seg_bw_s, min_bw_s, hr_bw_s;
  logic [7:0] tick_min_s, tick_hr_s;

  logic key_load_s, key_start_s, key_clear_s, key_ack_s;
  logic tick_s, load_ok_s, count_nz_s;

  decremento_bcd u_dec_seg (.valor(seg_r), .envolver(BCD_MAX_MS), .resultado(seg_dec_s), .prestamo(seg_bw_s));
  decremento_bcd u_dec_min (.valor(min_r), .envolver(BCD_MAX_MS), .resultado(min_dec_s), .prestamo(min_bw_s));
  decremento_bcd u_dec_hr  (.valor(hr_r),  .envolver(BCD_ZERO),   .resultado(hr_dec_s),  .prestamo(hr_bw_s));

  // Minutes only move on a seconds borrow, hours only on a minutes borrow as well.
  assign tick_min_s = seg_bw_s ? min_dec_s : min_r;
  assign tick_hr_s  = (seg_bw_s && min_bw_s) ? hr_dec_s : hr_r;

  assign key_load_s  = tecla_valida && (Tecla == KEY_LOAD);
  assign key_start_s = tecla_valida && (Tecla == KEY_START);
  assign key_clear_s = tecla_valida && (Tecla == KEY_CLEAR);
  assign key_ack_s   = tecla_valida && (Tecla == KEY_ACK);
  // Any qualified key steals the tick of the same cycle.
  assign tick_s      = tick_1hz && !tecla_valida;
  assign load_ok_s   = bcd_ok(Segundos, BCD_MAX_MS) && bcd_ok(Minutos, BCD_MAX_MS) && bcd_ok(Horas, BCD_MAX_H);
  assign count_nz_s  = |{hr_r, min_r, seg_r};

`ifdef CRONO_ALARM_TIMEOUT_EN
  logic [4:0] to_cnt_r;

  // Ticks seen while in DONE; held at zero in every other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= 5'd0;
    end else if (state_r != ST_DONE) begin
      to_cnt_r <= 5'd0;
    end else if (tick_s) begin
      to_cnt_r <= to_cnt_r + 5'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`endif

  // Next state, next count and error pulse.
  always_comb begin
    state_s = state_r;
    seg_s   = seg_r;
    min_s   = min_r;
    hr_s    = hr_r;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_load_s) begin
          if (load_ok_s) begin
            {hr_s, min_s, seg_s} = {Horas, Minutos, Segundos};
          end else begin
            err_s = 1'b1;
          end
        end else if (key_start_s && count_nz_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (key_start_s) begin
          state_s = ST_PAUSE;
        end else if (key_clear_s) begin
          {hr_s, min_s, seg_s} = 24'h00_00_00;
          state_s = ST_IDLE;
        end else if (tick_s) begin
          if (seg_bw_s && min_bw_s && hr_bw_s) begin
            {hr_s, min_s, seg_s} = 24'h00_00_00;
            state_s = ST_DONE;
          end else begin
            {hr_s, min_s, seg_s} = {tick_hr_s, tick_min_s, seg_dec_s};
            state_s = ({tick_hr_s, tick_min_s, seg_dec_s} == 24'h00_00_00) ? ST_DONE : ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (key_start_s) begin
          state_s = ST_RUN;
        end else if (key_clear_s) begin
          {hr_s, min_s, seg_s} = 24'h00_00_00;
          state_s = ST_IDLE;
        end else if (key_load_s) begin
          if (load_ok_s) begin
            {hr_s, min_s, seg_s} = {Horas, Minutos, Segundos};
            state_s = ST_IDLE;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        {hr_s, min_s, seg_s} = 24'h00_00_00;
        if (key_ack_s || key_clear_s) begin
          state_s = ST_IDLE;
`ifdef CRONO_ALARM_TIMEOUT_EN
        end else if (tick_s && (to_cnt_r == TIMEOUT_TICKS - 5'd1)) begin
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        {hr_s, min_s, seg_s} = 24'h00_00_00;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      seg_r    <= 8'h00;
      min_r    <= 8'h00;
      hr_r     <= 8'h00;
      alarma_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      seg_r    <= seg_s;
      min_r    <= min_s;
      hr_r     <= hr_s;
      alarma_r <= (state_s == ST_DONE);
      err_r    <= err_s;
    end
  end

  assign Segundos_C  = seg_r;
  assign Minutos_C   = min_r;
  assign Horas_C     = hr_r;
  assign alarma      = alarma_r;
  assign error_carga = err_r;
  assign estado      = state_r;

endmodule

// File: tb/tb_cronometro_control.sv
// Self-checking bench for cronometro_control: directed scenarios plus random
// keys/ticks, compared every cycle against a seconds-count reference model.
module tb_cronometro_control;

  logic       clk;
  logic       reset;
  logic [7:0] Tecla;
  logic       tecla_valida;
  logic       tick_1hz;
  logic [7:0] Segundos, Minutos, Horas;
  logic [7:0] Segundos_C, Minutos_C, Horas_C;
  logic       alarma, error_carga;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining time as plain seconds, state as 0..3.
  int m_state;
  int m_total;
  int m_err;
  int m_to;

  cronometro_control dut (
    .clk(clk), .reset(reset), .Tecla(Tecla), .tecla_valida(tecla_valida),
    .tick_1hz(tick_1hz), .Segundos(Segundos), .Minutos(Minutos), .Horas(Horas),
    .Segundos_C(Segundos_C), .Minutos_C(Minutos_C), .Horas_C(Horas_C),
    .alarma(alarma), .error_carga(error_carga), .estado(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int x);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(x / 10);
    lo = 4'(x % 10);
    return {hi, lo};
  endfunction

  function automatic int digit_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (digit_val(v) <= lim);
  endfunction

  function automatic bit preset_ok();
    return field_ok(Segundos, 59) && field_ok(Minutos, 59) && field_ok(Horas, 23);
  endfunction

  function automatic int preset_total();
    return digit_val(Horas) * 3600 + digit_val(Minutos) * 60 + digit_val(Segundos);
  endfunction

  task automatic model_reset();
    m_state = 0; m_total = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] k, input bit tk);
    bit t;
    t = tk && !kv;
    m_err = 0;
    case (m_state)
      0: begin
        if (kv && k == 8'h75) begin
          if (preset_ok()) m_total = preset_total();
          else m_err = 1;
        end else if (kv && k == 8'h29 && m_total > 0) m_state = 1;
      end
      1: begin
        if (kv && k == 8'h29) m_state = 2;
        else if (kv && k == 8'h66) begin m_total = 0; m_state = 0; end
        else if (t) begin
          m_total = m_total - 1;
          if (m_total == 0) begin m_state = 3; m_to = 0; end
        end
      end
      2: begin
        if (kv && k == 8'h29) m_state = 1;
        else if (kv && k == 8'h66) begin m_total = 0; m_state = 0; end
        else if (kv && k == 8'h75) begin
          if (preset_ok()) begin m_total = preset_total(); m_state = 0; end
          else m_err = 1;
        end
      end
      default: begin
        if (kv && (k == 8'h5A || k == 8'h66)) m_state = 0;
`ifdef CRONO_ALARM_TIMEOUT_EN
        else if (t) begin
          m_to = m_to + 1;
          if (m_to == 30) m_state = 0;
        end
`endif
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".seg"},    32'(Segundos_C),  32'(to_bcd(m_total % 60)));
    check({tag, ".min"},    32'(Minutos_C),   32'(to_bcd((m_total / 60) % 60)));
    check({tag, ".hr"},     32'(Horas_C),     32'(to_bcd(m_total / 3600)));
    check({tag, ".estado"}, 32'(estado),      32'(m_state));
    check({tag, ".alarma"}, 32'(alarma),      32'(m_state == 3));
    check({tag, ".err"},    32'(error_carga), 32'(m_err));
  endtask

  task automatic step(input string tag, input bit kv, input logic [7:0] k, input bit tk);
    tecla_valida = kv; Tecla = k; tick_1hz = tk;
    @(posedge clk);
    model_step(kv, k, tk);
    #1;
    compare_all(tag);
    tecla_valida = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic set_preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Horas = h; Minutos = m; Segundos = s;
  endtask

  // Drop reset between clock edges and check the outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk);
    #1 compare_all({tag, ".held"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; Tecla = 8'h00; tecla_valida = 1'b0; tick_1hz = 1'b0;
    set_preset(8'h00, 8'h00, 8'h00);
    model_reset();
    #3 compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // 00:01:05 counted down to zero
    set_preset(8'h00, 8'h01, 8'h05);
    step("d1.load", 1'b1, 8'h75, 1'b0);
    step("d1.start", 1'b1, 8'h29, 1'b0);
    for (int i = 0; i < 65; i++) begin
      step("d1.tick", 1'b0, 8'h00, 1'b1);
      if (i == 0) check("d1.first", 32'({Horas_C, Minutos_C, Segundos_C}), 32'h00_01_04);
      if (i == 5) check("d1.borrow", 32'({Horas_C, Minutos_C, Segundos_C}), 32'h00_00_59);
      step("d1.gap", 1'b0, 8'h00, 1'b0);
    end
    check("d1.done", 32'(estado), 32'd3);
    check("d1.alarma", 32'(alarma), 32'd1);
    step("d1.ack", 1'b1, 8'h5A, 1'b0);

    // invalid seconds field
    set_preset(8'h00, 8'h00, 8'h60);
    step("d2.bad", 1'b1, 8'h75, 1'b0);
    check("d2.pulse", 32'(error_carga), 32'd1);
    step("d2.after", 1'b0, 8'h00, 1'b0);
    check("d2.pulse_end", 32'(error_carga), 32'd0);
    set_preset(8'h05, 8'h0A, 8'h00);
    step("d2.badnib", 1'b1, 8'h75, 1'b0);
    set_preset(8'h24, 8'h00, 8'h00);
    step("d2.badhr", 1'b1, 8'h75, 1'b0);

    // 01:00:00 borrow across two fields, then pause
    set_preset(8'h01, 8'h00, 8'h00);
    step("d3.load", 1'b1, 8'h75, 1'b0);
    step("d3.start", 1'b1, 8'h29, 1'b0);
    step("d3.tick", 1'b0, 8'h00, 1'b1);
    check("d3.val", 32'({Horas_C, Minutos_C, Segundos_C}), 32'h00_59_59);
    step("d3.pause", 1'b1, 8'h29, 1'b0);
    for (int i = 0; i < 3; i++) step("d3.ptick", 1'b0, 8'h00, 1'b1);
    check("d3.hold", 32'({Horas_C, Minutos_C, Segundos_C}), 32'h00_59_59);
    step("d3.clear", 1'b1, 8'h66, 1'b0);

    // key and tick in the same cycle
    set_preset(8'h00, 8'h00, 8'h10);
    step("d4.load", 1'b1, 8'h75, 1'b0);
    step("d4.start", 1'b1, 8'h29, 1'b0);
    step("d4.both", 1'b1, 8'h29, 1'b1);
    check("d4.state", 32'(estado), 32'd2);
    check("d4.val", 32'(Segundos_C), 32'h10);

    // reset mid-run
    set_preset(8'h12, 8'h34, 8'h56);
    step("d5.load", 1'b1, 8'h75, 1'b0);
    step("d5.start", 1'b1, 8'h29, 1'b0);
    step("d5.tick", 1'b0, 8'h00, 1'b1);
    async_reset("d5");
    step("d5.restart", 1'b1, 8'h29, 1'b0);
    check("d5.idle", 32'(estado), 32'd0);

    // DONE with no acknowledge for 30 ticks
    set_preset(8'h00, 8'h00, 8'h02);
    step("d6.load", 1'b1, 8'h75, 1'b0);
    step("d6.start", 1'b1, 8'h29, 1'b0);
    step("d6.t1", 1'b0, 8'h00, 1'b1);
    step("d6.t2", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step("d6.dtick", 1'b0, 8'h00, 1'b1);
      step("d6.gap", 1'b0, 8'h00, 1'b0);
    end
`ifdef CRONO_ALARM_TIMEOUT_EN
    check("d6.timeout", 32'(estado), 32'd0);
    check("d6.alarm_off", 32'(alarma), 32'd0);
`else
    check("d6.still", 32'(alarma), 32'd1);
    step("d6.ack", 1'b1, 8'h5A, 1'b0);
    check("d6.acked", 32'(alarma), 32'd0);
`endif

    // random keys, ticks and presets
    for (int n = 0; n < 2500; n++) begin
      logic [7:0] k;
      bit kv;
      bit tk;
      if (n % 60 == 0) begin
        case ($urandom_range(0, 2))
          0: set_preset(8'h00, to_bcd($urandom_range(0, 1)), to_bcd($urandom_range(0, 20)));
          1: set_preset(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59)));
          default: set_preset(8'($urandom), 8'($urandom), 8'($urandom));
        endcase
      end
      case ($urandom_range(0, 7))
        0: k = 8'h75;
        1: k = 8'h29;
        2: k = 8'h66;
        3: k = 8'h5A;
        default: k = 8'($urandom);
      endcase
      kv = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 2) == 0);
      step("rnd", kv, k, tk);
      if ($urandom_range(0, 699) == 0) async_reset("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
